battle_engine: RTL

- Turn-based combat sequencer between the game-logic/map FSM and the vga renderer.
- On a start request it runs hero-versus-enemy rounds at a visible pace.
- It drives the renderer's isBattle and live curEnemy fields, and returns the updated hero record and the outcome to game logic.
- Outputs use the renderer's packed formats:
  - hero: [34:25] hp, [24:18] attack, [17:11] defend, [10:7] key, [6:0] coins.
  - curEnemy: [23:21] type, [20:12] hp, [11:6] attack, [5:0] defend.

---
 rtl/battle_engine_if.sv | 24 ++
 rtl/battle_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/battle_engine_if.sv
// rtl/battle_engine_if.sv - request/record bus between game logic, battle engine and renderer
interface battle_engine_if;
    logic        start;
    logic [23:0] enemy_in;
    logic [34:0] hero_in;
    logic [6:0]  reward_in;
    logic        isBattle;
    logic [23:0] curEnemy;
    logic [34:0] hero_out;
    logic        busy;
    logic        done;
    logic        win;
    logic        aborted;

    modport master (
        output start, enemy_in, hero_in, reward_in,
        input  isBattle, curEnemy, hero_out, busy, done, win, aborted
    );

    modport slave (
        input  start, enemy_in, hero_in, reward_in,
        output isBattle, curEnemy, hero_out, busy, done, win, aborted
    );
endinterface

// File: rtl/battle_engine.sv
// rtl/battle_engine.sv - turn-based hero-versus-enemy combat sequencer
module battle_engine #(
    parameter int ROUND_TICKS = 25000000,
    parameter int HOLD_TICKS  = 50000000
) (
    input  logic           clk_100mhz,
    input  logic           rst,
    battle_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CHECK, HERO_HIT, WAIT_E, ENEMY_HIT, WAIT_H, FINISH
    } state_t;

    // WAIT_x spends ROUND_TICKS-1 cycles, so the counter runs from ROUND_TICKS-2 down to 0
    localparam logic [31:0] ROUND_LOAD = 32'(ROUND_TICKS - 2);
    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_TICKS - 1);

    state_t      state;
    logic [31:0] tick;
    logic [6:0]  reward;
    logic [34:0] hero_r;
    logic [23:0] enemy_r;
    logic        is_battle;
    logic        busy_r;
    logic        done_r;
    logic        win_r;
    logic        aborted_r;

    logic [9:0] hero_hp;
    logic [6:0] hero_atk;
    logic [6:0] hero_def;
    logic [6:0] hero_coins;
    logic [8:0] enemy_hp;
    logic [5:0] enemy_atk;
    logic [5:0] enemy_def;
    logic [6:0] dh;
    logic [6:0] de;
    logic [7:0] coin_sum;
    logic [6:0] coins_won;

    assign hero_hp    = hero_r[34:25];
    assign hero_atk   = hero_r[24:18];
    assign hero_def   = hero_r[17:11];
    assign hero_coins = hero_r[6:0];
    assign enemy_hp   = enemy_r[20:12];
    assign enemy_atk  = enemy_r[11:6];
    assign enemy_def  = enemy_r[5:0];

    assign dh = (hero_atk > {1'b0, enemy_def}) ? (hero_atk - {1'b0, enemy_def}) : 7'd0;
    assign de = ({1'b0, enemy_atk} > hero_def) ? ({1'b0, enemy_atk} - hero_def) : 7'd0;

    assign coin_sum  = {1'b0, hero_coins} + {1'b0, reward};
    assign coins_won = coin_sum[7] ? 7'h7f : coin_sum[6:0];

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            reward    <= '0;
            hero_r    <= '0;
            enemy_r   <= '0;
            is_battle <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            win_r     <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        enemy_r   <= bus.enemy_in;
                        hero_r    <= bus.hero_in;
                        reward    <= bus.reward_in;
                        win_r     <= 1'b0;
                        aborted_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (dh == 7'd0) begin
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        is_battle <= 1'b1;
                        state     <= HERO_HIT;
                    end
                end
                HERO_HIT: begin
                    if (enemy_hp <= {2'b00, dh}) begin
                        enemy_r[20:12] <= 9'd0;
                        win_r          <= 1'b1;
                        hero_r[6:0]    <= coins_won;
                        tick           <= HOLD_LOAD;
                        state          <= FINISH;
                    end else begin
                        enemy_r[20:12] <= enemy_hp - {2'b00, dh};
                        tick           <= ROUND_LOAD;
                        state          <= WAIT_E;
                    end
                end
                WAIT_E: begin
                    if (tick == 32'd0) state <= ENEMY_HIT;
                    else               tick  <= tick - 32'd1;
                end
                ENEMY_HIT: begin
                    // a zero-damage enemy never kills, even a hero already at 0 hp
                    if (de != 7'd0 && hero_hp <= {3'b000, de}) begin
                        hero_r[34:25] <= 10'd0;
                        win_r         <= 1'b0;
                        tick          <= HOLD_LOAD;
                        state         <= FINISH;
                    end else begin
                        hero_r[34:25] <= hero_hp - {3'b000, de};
                        tick          <= ROUND_LOAD;
                        state         <= WAIT_H;
                    end
                end
                WAIT_H: begin
                    if (tick == 32'd0) state <= HERO_HIT;
                    else               tick  <= tick - 32'd1;
                end
                FINISH: begin
                    if (tick == 32'd0) begin
                        is_battle <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tick <= tick - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.isBattle = is_battle;
    assign bus.curEnemy = enemy_r;
    assign bus.hero_out = hero_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.win      = win_r;
    assign bus.aborted  = aborted_r;
endmodule
